msh_node_outp_arb: RTL
======================

Name: msh_node_outp_arb

Overview:
- Output-port arbiter/scheduler for one mesh node output link.
- Shares the link between NUM_REQ requesters (N/S/E/W/local input ports) with round-robin, packet-locked arbitration.
- Gates flits on downstream credits, so the link never overruns the neighbour's input buffer.
- Sits between the node input-port buffers and the output-link register stage, clocked on mclk.

Parameters:
- NUM_REQ, 5, number of requesters (one per input port); must be >= 2.
- MAX_CREDITS, 8, downstream buffer depth in flits; also the credit reset value.
- CREDIT_W, $clog2(MAX_CREDITS+1), credit counter width (derived localparam, not overridable).

Ports:
- mclk  input  1  node clock; all state on rising edge.
- i_reset_n  input  1  reset; asynchronous assert, active-low.
- i_vld  input  NUM_REQ  per-requester flit valid; once raised, held until that flit transfers.
- i_eop  input  NUM_REQ  per-requester end-of-packet, qualified by i_vld.
- i_crd_rtn  input  1  downstream returns one credit this cycle.
- o_gnt  output  NUM_REQ  one-hot grant; flit transfers when o_gnt[i] & i_vld[i].
- o_busy  output  1  high while a packet owns the link (state BUSY).
- o_owner  output  $clog2(NUM_REQ)  index of current owner; valid when o_busy.
- o_crd_cnt  output  CREDIT_W  current available credits.
- o_crd_err  output  1  sticky: credit returned while counter already at MAX_CREDITS.

Behaviour:
- Interface decision: one clock (mclk); reset i_reset_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, rr_ptr=0, owner=0.
  - o_gnt=0, o_busy=0, o_owner=0, o_crd_cnt=MAX_CREDITS, o_crd_err=0.
- Reset mid-packet: all state returns to reset values immediately. The partial packet is abandoned; upstream is responsible.
- FSM IDLE:
  - o_gnt=0.
  - If any i_vld, pick the first requester with i_vld set, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Next cycle: state=BUSY, owner=winner.
  - Arbitration uses i_vld only; credits are not checked in IDLE.
  - Latency: i_vld rising in cycle T gives o_gnt in cycle T+1 (given credits); first transfer in T+1.
- FSM BUSY:
  - o_gnt[owner] = (o_crd_cnt != 0); all other bits 0.
  - o_gnt is decoded from registers only, with no combinational path from i_vld.
  - Transfer = o_gnt[owner] & i_vld[owner].
  - i_vld[owner] low is a bubble: no transfer, and BUSY is held.
  - Transfer with i_eop[owner]: next state IDLE, rr_ptr = (owner+1) mod NUM_REQ.
  - Minimum one IDLE cycle between packets; at most one grant change per two cycles.
- Fairness: packet-granular round-robin. A requester waits at most NUM_REQ-1 packets.
- Credit counter:
  - Transfer only: -1.
  - i_crd_rtn only: +1.
  - Both in the same cycle: unchanged.
  - Never decrements below 0; cannot happen, because a transfer requires cnt != 0.
  - i_crd_rtn with cnt == MAX_CREDITS and no simultaneous transfer: cnt stays at MAX_CREDITS and o_crd_err sets. o_crd_err is cleared only by reset.
  - cnt == 0 in BUSY: o_gnt drops next to the counter update. The grant resumes the cycle after a credit return.
- Single-flit packet (i_eop set on the first flit): BUSY for exactly one transfer cycle.
- Requester dropping i_vld in IDLE before being chosen is legal; it is simply not considered.

Test Plan:
- Single requester: reset, i_vld[2]=1 for 3 flits, i_eop on 3rd, ample credits -> o_gnt=5'b00100 in cycles 1-3; IDLE in cycle 4; rr_ptr=3; o_crd_cnt=5.
- Round-robin: i_vld[0..4] all held, 1-flit packets -> grant order 0,1,2,3,4,0, each grant separated by one IDLE cycle.
- Credit stall: MAX_CREDITS=8, one 10-flit packet, no returns -> 8 transfers, o_gnt=0 with o_busy=1. A single i_crd_rtn pulse -> exactly one more transfer.
- Simultaneous transfer and i_crd_rtn at o_crd_cnt=3 -> o_crd_cnt stays 3. i_crd_rtn at o_crd_cnt=8 -> o_crd_err=1 and sticky, cnt stays 8.
- Packet lock: owner 1 mid-packet, i_vld[0] asserted -> no grant to 0 until the eop transfer of 1. Then 0 is granted only if 2,3,4 are idle.
- Async reset mid-packet: drop i_reset_n between clock edges while BUSY -> outputs reach reset values without a clock edge; o_crd_cnt=8.

Source files
------------

// File: rtl/msh_node_outp_arb.sv
`default_nettype none
// ============================================================================
//  Module   : msh_node_outp_arb
//  Purpose  : Output-port arbiter for one mesh node link. Round-robin,
//             packet-locked arbitration among NUM_REQ input ports, with
//             downstream credit gating so the neighbour's buffer never
//             overruns.
//  Revision : 1.0  initial release
// ============================================================================
module msh_node_outp_arb #(
    parameter  int NUM_REQ     = 5,
    parameter  int MAX_CREDITS = 8,
    localparam int CREDIT_W    = $clog2(MAX_CREDITS + 1),
    localparam int OWN_W       = $clog2(NUM_REQ)
) (
    input  logic                mclk,
    input  logic                i_reset_n,
    input  logic [NUM_REQ-1:0]  i_vld,
    input  logic [NUM_REQ-1:0]  i_eop,
    input  logic                i_crd_rtn,
    output logic [NUM_REQ-1:0]  o_gnt,
    output logic                o_busy,
    output logic [OWN_W-1:0]    o_owner,
    output logic [CREDIT_W-1:0] o_crd_cnt,
    output logic                o_crd_err
);

    localparam logic [CREDIT_W-1:0] CRD_MAX  = CREDIT_W'(MAX_CREDITS);
    localparam logic [OWN_W-1:0]    LAST_IDX = OWN_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_q,   state_d;
    logic [OWN_W-1:0]    owner_q,   owner_d;
    logic [OWN_W-1:0]    rr_ptr_q,  rr_ptr_d;
    logic [CREDIT_W-1:0] crd_cnt_q, crd_cnt_d;
    logic                crd_err_q, crd_err_d;

    logic                win_found;
    logic [OWN_W-1:0]    win_idx;
    logic                xfer;
    logic [OWN_W-1:0]    owner_nxt;

    // Round-robin search starting at rr_ptr; walking offsets from the far end
    // down to zero lets the closest valid requester overwrite the others.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int sum;
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            if (i_vld[sum]) begin
                win_found = 1'b1;
                win_idx   = OWN_W'(sum);
            end
        end
    end

    // A flit moves only when the owner is valid and a credit is available.
    assign xfer      = (state_q == ST_BUSY) && (crd_cnt_q != '0) && i_vld[owner_q];
    assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    // Next-state logic for the packet FSM, round-robin pointer and credits.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        crd_cnt_d = crd_cnt_q;
        crd_err_d = crd_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_BUSY;
                    owner_d = win_idx;
                end
            end
            ST_BUSY: begin
                if (xfer && i_eop[owner_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_nxt;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Transfer and return in the same cycle cancel out; an overflowing
        // return leaves the count saturated and flags a protocol error.
        unique case ({xfer, i_crd_rtn})
            2'b10: crd_cnt_d = crd_cnt_q - 1'b1;
            2'b01: begin
                if (crd_cnt_q == CRD_MAX) begin
                    crd_err_d = 1'b1;
                end else begin
                    crd_cnt_d = crd_cnt_q + 1'b1;
                end
            end
            default: crd_cnt_d = crd_cnt_q;
        endcase
    end

    // State registers; reset abandons any packet in flight immediately.
    always_ff @(posedge mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            crd_cnt_q <= CRD_MAX;
            crd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            crd_cnt_q <= crd_cnt_d;
            crd_err_q <= crd_err_d;
        end
    end

    // Grant is decoded purely from registers so i_vld never feeds o_gnt.
    always_comb begin
        o_gnt = '0;
        if ((state_q == ST_BUSY) && (crd_cnt_q != '0)) begin
            o_gnt[owner_q] = 1'b1;
        end
    end

    assign o_busy    = (state_q == ST_BUSY);
    assign o_owner   = owner_q;
    assign o_crd_cnt = crd_cnt_q;
    assign o_crd_err = crd_err_q;

endmodule
`default_nettype wire
